// File: rtl/serial_subtractor.sv
// Bit-serial unsigned/two's-complement subtractor: one bit per clock, LSB first.
// The result and its flags are published only on the cycle that finishes the last bit.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, acc_reg, acc_next;
    logic [WIDTH:0]   acc_wide;
    logic [CW-1:0]    cnt_reg;
    logic             br_reg, br_next, d_bit, last_bit;

    always_comb begin
        d_bit    = a_reg[0] ^ b_reg[0] ^ br_reg;
        br_next  = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & br_reg);
        acc_wide = {d_bit, acc_reg};
        acc_next = acc_wide[WIDTH:1];
        last_bit = (cnt_reg == CW'(WIDTH - 1));
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg == SHIFT);
    assign done = (state_reg == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Operands shift right so bit 0 is always the bit being processed; the
    // partial difference fills acc_reg from the top and stays internal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            acc_reg  <= '0;
            br_reg   <= 1'b0;
            cnt_reg  <= '0;
            diff     <= '0;
            borrow   <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        acc_reg <= '0;
                        br_reg  <= 1'b0;
                        cnt_reg <= '0;
                    end
                end
                SHIFT: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    acc_reg <= acc_next;
                    br_reg  <= br_next;
                    if (!last_bit) cnt_reg <= cnt_reg + 1'b1;
                    // On the last bit a_reg[0]/b_reg[0] hold the operand sign bits.
                    if (last_bit) begin
                        diff     <= acc_next;
                        borrow   <= br_next;
                        zero     <= (acc_next == '0);
                        overflow <= (a_reg[0] != b_reg[0]) &
                                    (acc_next[WIDTH-1] != a_reg[0]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: arithmetic reference model checked every cycle,
// plus directed literal cases, reset abort, start-ignore and back-to-back runs.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] diff;
    logic         borrow, zero, overflow, busy, done;

    int tests = 0;
    int fails = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .diff(diff), .borrow(borrow), .zero(zero), .overflow(overflow),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Returns {diff, borrow, zero, overflow} from plain integer arithmetic.
    function automatic logic [W+2:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        int ux, uy, sx, sy, ud, sd;
        logic [W-1:0] d;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        ud = ux - uy;
        sd = sx - sy;
        d  = ud[W-1:0];
        return {d, (ud < 0), (d == '0), (sd < -(2 ** (W - 1)) || sd > (2 ** (W - 1)) - 1)};
    endfunction

    // Behavioural model: phase 0 idle, 1..W busy, W+1 done.
    int           phase = 0;
    logic [W-1:0] ma = '0, mb = '0, m_diff = '0;
    logic         m_borrow = 1'b0, m_zero = 1'b0, m_ovf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= 0;
            m_diff   <= '0;
            m_borrow <= 1'b0;
            m_zero   <= 1'b0;
            m_ovf    <= 1'b0;
        end else if (phase == 0) begin
            if (start) begin
                ma    <= a;
                mb    <= b;
                phase <= 1;
            end
        end else if (phase < W) begin
            phase <= phase + 1;
        end else if (phase == W) begin
            {m_diff, m_borrow, m_zero, m_ovf} <= ref_sub(ma, mb);
            phase <= W + 1;
        end else begin
            phase <= 0;
        end
    end

    logic exp_busy, exp_done;
    always @(negedge clk) begin
        exp_busy = (phase >= 1) && (phase <= W);
        exp_done = (phase == W + 1);
        tests++;
        if ({busy, done, diff, borrow, zero, overflow} !==
            {exp_busy, exp_done, m_diff, m_borrow, m_zero, m_ovf}) begin
            fails++;
            $display("FAIL cycle_check t=%0t busy/done/diff/borrow/zero/ovf got %b/%b/%h/%b/%b/%b expected %b/%b/%h/%b/%b/%b",
                     $time, busy, done, diff, borrow, zero, overflow,
                     exp_busy, exp_done, m_diff, m_borrow, m_zero, m_ovf);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] ed, input logic eb, input logic ez,
                          input logic eo, input string name);
        int lat;
        bit seen;
        seen = 0;
        lat  = 0;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                lat  = i;
                break;
            end
        end
        chk({name, "_done_seen"}, int'(seen), 1);
        chk({name, "_latency"}, lat, W - 1);
        chk({name, "_result"}, int'({diff, borrow, zero, overflow}), int'({ed, eb, ez, eo}));
        $display("[TB] %s a=%h b=%h -> diff=%h borrow=%b zero=%b ovf=%b", name, x, y, diff, borrow, zero, overflow);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, done_cnt, got, last_done, ndone;
        logic [W+2:0] r;
        logic [W-1:0] x, y;

        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({diff, borrow, zero, overflow, busy, done}), 0);
        rst = 1'b0;

        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, "sub_05_03");
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, "sub_03_05");
        run_op(8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0, "sub_5a_5a");
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, "sub_80_01");
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1, "sub_7f_ff");

        // Operand changes and a start pulse during SHIFT must be ignored.
        busy_cnt = 0; done_cnt = 0; got = 0;
        @(negedge clk);
        a = 8'h10; b = 8'h01; start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 3) begin a = 8'hAA; b = 8'h55; start = 1'b1; end
            if (i == 4) start = 1'b0;
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            if (done) got = int'(diff);
        end
        chk("ignore_busy_cycles", busy_cnt, W);
        chk("ignore_done_pulses", done_cnt, 1);
        chk("ignore_diff", got, 8'h0F);
        $display("[TB] ignore_start busy_cycles=%0d done_pulses=%0d diff=%h", busy_cnt, done_cnt, got);

        // Asynchronous reset in the 4th SHIFT cycle aborts the operation.
        @(negedge clk);
        a = 8'h33; b = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", int'({diff, borrow, zero, overflow, busy, done}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            done_cnt += int'(done);
        end
        chk("abort_no_done", done_cnt, 0);
        $display("[TB] reset_abort done_pulses_after=%0d", done_cnt);
        run_op(8'h33, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0, "after_reset");

        // start held high: one operation every W+2 cycles.
        last_done = -1; ndone = 0;
        @(negedge clk);
        a = W'($urandom); b = W'($urandom); start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a = W'($urandom);
            b = W'($urandom);
            if (done) begin
                if (last_done >= 0) chk("b2b_period", i - last_done, W + 2);
                $display("[TB] b2b done at cycle %0d diff=%h borrow=%b zero=%b ovf=%b", i, diff, borrow, zero, overflow);
                last_done = i;
                ndone++;
            end
        end
        start = 1'b0;
        chk("b2b_count", ndone, 4);
        repeat (12) @(negedge clk);

        for (int k = 0; k < 25; k++) begin
            x = W'($urandom);
            y = (k % 5 == 0) ? x : W'($urandom);
            r = ref_sub(x, y);
            run_op(x, y, r[W+2:3], r[2], r[1], r[0], "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
